// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with a one-cycle terminal-count pulse and optional periodic auto-reload
module countdown_timer #(
    parameter int WIDTH       = 5,
    parameter int AUTO_RELOAD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] load_val,
    input  logic             pause,
    input  logic             abort,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done
);
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             done_q, done_d;
    logic             launch, last;
    // start only counts in IDLE with a nonzero value and no abort; a count of 1 is the terminal step
    assign launch = start && !abort && (load_val != '0);
    assign last   = cnt_q <= ONE;
    // state and datapath registers, rst overrides everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end
    // next state: abort beats pause, one-shot mode falls back to IDLE on the terminal step
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = launch ? RUN : IDLE;
        else if (abort)
            state_d = IDLE;
        else if (!pause && last && AUTO_RELOAD == 0)
            state_d = IDLE;
    end
    // count, reload latch and done pulse; q is always 0 while IDLE so zero-length starts leave it alone
    always_comb begin
        cnt_d    = cnt_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (state_q == IDLE) begin
            if (launch) begin
                cnt_d    = load_val;
                reload_d = load_val;
            end
            done_d = start && !abort && (load_val == '0);
        end else if (abort) begin
            cnt_d = '0;
        end else if (!pause) begin
            done_d = last;
            cnt_d  = last ? ((AUTO_RELOAD != 0) ? reload_q : '0) : cnt_q - ONE;
        end
    end
    assign q    = cnt_q;
    assign busy = (state_q == RUN);
    assign done = done_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed vector table for one-shot mode plus hand sequences for auto-reload
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [4:0] load_val = '0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [4:0] q0, q1;
    logic       busy0, busy1, done0, done1;
    int         n_cmp = 0;
    int         n_err = 0;

    typedef struct {
        logic       rst;
        logic       start;
        logic [4:0] lv;
        logic       pause;
        logic       abort;
        logic [4:0] eq;
        logic       eb;
        logic       ed;
    } vec_t;
    vec_t vecs[$];

    countdown_timer #(.WIDTH(5), .AUTO_RELOAD(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .pause(pause),
        .abort(abort), .q(q0), .busy(busy0), .done(done0)
    );
    countdown_timer #(.WIDTH(5), .AUTO_RELOAD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .load_val(load_val), .pause(pause),
        .abort(abort), .q(q1), .busy(busy1), .done(done1)
    );

    always #5 clk = ~clk;

    function automatic void add(input logic r, input logic s, input logic [4:0] lv, input logic p,
                                input logic a, input logic [4:0] eq, input logic eb, input logic ed);
        vec_t v;
        v.rst = r; v.start = s; v.lv = lv; v.pause = p; v.abort = a;
        v.eq = eq; v.eb = eb; v.ed = ed;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic [4:0] lv, input logic p, input logic a);
        rst = r; start = s; load_val = lv; pause = p; abort = a;
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input int eq, input int eb, input int ed);
        chk({name, " q"}, int'(q1), eq);
        chk({name, " busy"}, int'(busy1), eb);
        chk({name, " done"}, int'(done1), ed);
    endtask

    initial begin
        // reset and basic one-shot count of 5
        add(1,0,0,0,0, 0,0,0);
        add(1,0,0,0,0, 0,0,0);
        add(0,1,5,0,0, 5,1,0);
        add(0,0,0,0,0, 4,1,0);
        add(0,0,0,0,0, 3,1,0);
        add(0,0,0,0,0, 2,1,0);
        add(0,0,0,0,0, 1,1,0);
        add(0,0,0,0,0, 0,0,1);
        add(0,0,0,0,0, 0,0,0);
        // pause for two cycles at q=3
        add(0,1,5,0,0, 5,1,0);
        add(0,0,0,0,0, 4,1,0);
        add(0,0,0,0,0, 3,1,0);
        add(0,0,0,1,0, 3,1,0);
        add(0,0,0,1,0, 3,1,0);
        add(0,0,0,0,0, 2,1,0);
        add(0,0,0,0,0, 1,1,0);
        add(0,0,0,0,0, 0,0,1);
        add(0,0,0,0,0, 0,0,0);
        // abort at q=2, then a fresh count of 2
        add(0,1,6,0,0, 6,1,0);
        add(0,0,0,0,0, 5,1,0);
        add(0,0,0,0,0, 4,1,0);
        add(0,0,0,0,0, 3,1,0);
        add(0,0,0,0,0, 2,1,0);
        add(0,0,0,0,1, 0,0,0);
        add(0,0,0,0,0, 0,0,0);
        add(0,1,2,0,0, 2,1,0);
        add(0,0,0,0,0, 1,1,0);
        add(0,0,0,0,0, 0,0,1);
        add(0,0,0,0,0, 0,0,0);
        // zero-length count, and abort blocking start in IDLE
        add(0,1,0,0,0, 0,0,1);
        add(0,0,0,0,0, 0,0,0);
        add(0,1,7,0,1, 0,0,0);
        add(0,0,0,0,0, 0,0,0);
        // abort outranks pause; pause is ignored in IDLE
        add(0,1,3,0,0, 3,1,0);
        add(0,0,0,1,1, 0,0,0);
        add(0,1,2,1,0, 2,1,0);
        add(0,0,0,0,0, 1,1,0);
        add(0,0,0,0,0, 0,0,1);
        // max value, start retriggers ignored, rst mid-count at q=17
        add(0,1,31,0,0, 31,1,0);
        for (int i = 30; i >= 17; i--) add(0,1,9,0,0, 5'(i),1,0);
        add(1,1,9,0,0, 0,0,0);
        add(0,0,0,0,0, 0,0,0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].lv, vecs[i].pause, vecs[i].abort);
            chk($sformatf("v%0d q", i), int'(q0), int'(vecs[i].eq));
            chk($sformatf("v%0d busy", i), int'(busy0), int'(vecs[i].eb));
            chk($sformatf("v%0d done", i), int'(done0), int'(vecs[i].ed));
        end

        // auto-reload: N=3 with load_val changed mid-run, periodic done every 3 cycles
        drive(1,0,0,0,0);
        chk1("ar rst", 0, 0, 0);
        drive(0,1,3,0,0);
        chk1("ar start", 3, 1, 0);
        for (int i = 1; i <= 9; i++) begin
            drive(0, (i == 4), 7, 0, 0);
            chk1($sformatf("ar c%0d", i), 3 - (i % 3), 1, int'(i % 3 == 0));
        end
        drive(0,0,0,0,1);
        chk1("ar abort", 0, 0, 0);
        // auto-reload with N=1: done every cycle, q stays 1
        drive(0,1,1,0,0);
        chk1("ar1 start", 1, 1, 0);
        for (int i = 0; i < 4; i++) begin
            drive(0,0,0,0,0);
            chk1($sformatf("ar1 c%0d", i), 1, 1, 1);
        end
        drive(0,0,0,1,0);
        chk1("ar1 pause", 1, 1, 0);
        drive(0,0,0,0,0);
        chk1("ar1 resume", 1, 1, 1);
        drive(0,0,0,0,1);
        chk1("ar1 abort", 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
